prog_loader: RTL

- Boot-time program loader and RAM access arbiter for the 16x8 SAP-1 RAM.
- On request, it holds the CPU controller in reset, zero-fills the RAM, and streams program bytes into it over a valid/ready handshake.
- It then releases the CPU.
- When idle, it passes the CPU's MAR/bus/RI signals straight through to the RAM port.

---
 rtl/sap1_pkg.sv | 23 ++
 rtl/ram_port_mux.sv | 25 ++
 rtl/prog_loader.sv | 127 ++++++++++++
 3 files changed

// File: rtl/sap1_pkg.sv
// SAP-1 shared definitions: RAM geometry, opcodes and
// the program loader state encoding.
package sap1_pkg;

  localparam int RAM_ADDR_W = 4;
  localparam int RAM_DATA_W = 8;
  localparam int RAM_WORDS  = 16;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    RELEASE,
    DONE
  } ld_state_e;

endpackage

// File: rtl/ram_port_mux.sv
// RAM port selector: the loader owns the port while busy,
// the CPU owns it otherwise.
module ram_port_mux
  import sap1_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              busy,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we
);

  assign ram_addr  = busy ? ld_addr  : cpu_addr;
  assign ram_wdata = busy ? ld_wdata : cpu_wdata;
  assign ram_we    = busy ? ld_we    : cpu_we;

endmodule

// File: rtl/prog_loader.sv
// Boot loader: holds the CPU in reset, zero-fills RAM, streams
// a program in over valid/ready, then releases the CPU.
module prog_loader
  import sap1_pkg::*;
#(
  parameter int ADDR_W      = RAM_ADDR_W,
  parameter int DATA_W      = RAM_DATA_W,
  parameter int RELEASE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;
  localparam logic [3:0] REL_LAST = 4'(RELEASE_CYC - 1);

  ld_state_e         state, nxt;
  logic [ADDR_W-1:0] ptr, ptr_d;
  logic [ADDR_W:0]   cnt_d;
  logic [3:0]        rel, rel_d;
  logic              ld_we;
  logic [DATA_W-1:0] ld_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      count <= '0;
      rel   <= '0;
    end else begin
      state <= nxt;
      ptr   <= ptr_d;
      count <= cnt_d;
      rel   <= rel_d;
    end
  end

  always_comb begin
    nxt      = state;
    ptr_d    = ptr;
    cnt_d    = count;
    rel_d    = rel;
    busy     = 1'b0;
    cpu_rst  = 1'b0;
    in_ready = 1'b0;
    done     = 1'b0;
    ld_we    = 1'b0;
    ld_wdata = '0;
    unique case (state)
      IDLE: begin
        if (load_start) begin
          nxt   = CLEAR;
          ptr_d = '0;
          cnt_d = '0;
        end
      end
      CLEAR: begin
        busy    = 1'b1;
        cpu_rst = 1'b1;
        ld_we   = 1'b1;
        ptr_d   = ptr + 1'b1;
        if (ptr == PTR_MAX)
          nxt = LOAD;
      end
      LOAD: begin
        busy     = 1'b1;
        cpu_rst  = 1'b1;
        in_ready = 1'b1;
        ld_we    = in_valid;
        ld_wdata = in_data;
        if (in_valid) begin
          ptr_d = ptr + 1'b1;
          cnt_d = count + 1'b1;
          // the top word is the last one the RAM can hold
          if (in_last || ptr == PTR_MAX) begin
            nxt   = RELEASE;
            rel_d = '0;
          end
        end
      end
      RELEASE: begin
        busy    = 1'b1;
        cpu_rst = 1'b1;
        rel_d   = rel + 1'b1;
        if (rel == REL_LAST)
          nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  ram_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .busy      (busy),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .ld_addr   (ptr),
    .ld_wdata  (ld_wdata),
    .ld_we     (ld_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we)
  );

endmodule
